// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1 UART receiver, LSB first, with 3-sample mid-bit majority
// vote and a one-entry holding register (valid/rd_ack, ferr, sticky overrun).
module uart_rx_os #(
    parameter int unsigned BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned MID   = BAUD_DIV / 2;
    localparam int unsigned CNT_W = $clog2(BAUD_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             s1_q, s2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitc_q, bitc_d;
    logic [7:0]       shifter_q, shifter_d;
    logic             smp0_q, smp0_d;
    logic             smp1_q, smp1_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    logic             at_lo_c, at_mid_c, at_vote_c, at_wrap_c, vote_c;

    assign at_lo_c   = (cnt_q == CNT_W'(MID - 1));
    assign at_mid_c  = (cnt_q == CNT_W'(MID));
    assign at_vote_c = (cnt_q == CNT_W'(MID + 1));
    assign at_wrap_c = (cnt_q == CNT_W'(BAUD_DIV - 1));
    assign vote_c    = (smp0_q & smp1_q) | (smp0_q & s2_q) | (smp1_q & s2_q);

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= rx;
            s2_q <= s1_q;
        end
    end

    // Next-state, bit timing, vote sampling, delivery and handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitc_d    = bitc_q;
        shifter_d = shifter_q;
        smp0_d    = smp0_q;
        smp1_d    = smp1_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        overrun_d = overrun_q;

        if (state_q != S_IDLE) begin
            cnt_d = at_wrap_c ? '0 : cnt_q + CNT_W'(1);
            if (at_lo_c)  smp0_d = s2_q;
            if (at_mid_c) smp1_d = s2_q;
        end

        // Consumer read; a delivery on the same edge overrides this below.
        if (rd_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!s2_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (at_vote_c && vote_c) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (at_wrap_c) begin
                    state_d = S_DATA;
                    bitc_d  = 3'd0;
                end
            end
            S_DATA: begin
                if (at_vote_c) shifter_d = {vote_c, shifter_q[7:1]};
                if (at_wrap_c) begin
                    if (bitc_q == 3'd7) state_d = S_STOP;
                    else                bitc_d  = bitc_q + 3'd1;
                end
            end
            S_STOP: begin
                // Leave half a bit early so a back-to-back start edge is caught.
                if (at_vote_c) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    data_d    = shifter_q;
                    valid_d   = 1'b1;
                    ferr_d    = ~vote_c;
                    overrun_d = overrun_q | (valid_q & ~rd_ack);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bitc_q    <= 3'd0;
            shifter_q <= 8'h00;
            smp0_q    <= 1'b1;
            smp1_q    <= 1'b1;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitc_q    <= bitc_d;
            shifter_q <= shifter_d;
            smp0_q    <= smp0_d;
            smp1_q    <= smp1_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign ferr    = ferr_q;
    assign overrun = overrun_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os at BAUD_DIV=104.
module tb_uart_rx_os;

    localparam int unsigned BAUD_DIV = 104;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] data;
    logic       valid, ferr, overrun, busy;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int e0 = 0;
    int rise_cyc = -1;
    logic valid_prev = 1'b0;

    uart_rx_os #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rd_ack  (rd_ack),
        .data    (data),
        .valid   (valid),
        .ferr    (ferr),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Cycle index of the most recent rising clock edge.
    always @(posedge clk) cycle <= cycle + 1;

    // Record the edge on which valid rises.
    always @(negedge clk) begin
        if (valid && !valid_prev) rise_cyc = cycle;
        valid_prev = valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one 8N1 frame; optional one-cycle glitch at mid-bit of start/data bits.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int bitlen, input bit glitch);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        e0 = cycle + 1;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < bitlen; c++) begin
                if (glitch && i < 9 && c == bitlen / 2) rx = ~fr[i];
                else                                    rx = fr[i];
                @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic ack_one();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rb [3];
        int         lens [2];
        rb[0] = 8'h00; rb[1] = 8'hFF; rb[2] = 8'h55;
        lens[0] = 101; lens[1] = 107;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 0);
        check("rst_ferr", 32'(ferr), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        idle(5);

        // Nominal byte and latency
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1, BAUD_DIV, 1'b0);
        check("nom_latency", 32'(rise_cyc - e0), 992);
        check("nom_data", 32'(data), 32'hA5);
        check("nom_ferr", 32'(ferr), 0);
        check("nom_valid", 32'(valid), 1);
        ack_one();
        check("nom_ack_valid", 32'(valid), 0);
        idle(20);

        // Glitch rejection: 20-cycle low pulse
        rx = 1'b0;
        e0 = cycle + 1;
        @(negedge clk);
        @(negedge clk);
        check("gl_busy_e1", 32'(busy), 0);
        @(negedge clk);
        check("gl_busy_e2", 32'(busy), 1);
        repeat (17) @(negedge clk);
        rx = 1'b1;
        while (cycle < e0 + 55) @(negedge clk);
        check("gl_busy_e55", 32'(busy), 1);
        @(negedge clk);
        check("gl_busy_e56", 32'(busy), 0);
        idle(200);
        check("gl_valid", 32'(valid), 0);
        check("gl_data", 32'(data), 32'hA5);

        // Framing error: stop bit low
        send_frame(8'h3C, 1'b0, BAUD_DIV, 1'b0);
        check("fe_data", 32'(data), 32'h3C);
        check("fe_ferr", 32'(ferr), 1);
        check("fe_valid", 32'(valid), 1);
        idle(200);
        check("fe_idle_busy", 32'(busy), 0);
        check("fe_hold_data", 32'(data), 32'h3C);
        ack_one();
        check("fe_ack_valid", 32'(valid), 0);
        check("fe_ack_ferr", 32'(ferr), 1);
        idle(20);

        // Overrun: two frames back-to-back without ack
        send_frame(8'h11, 1'b1, BAUD_DIV, 1'b0);
        send_frame(8'h22, 1'b1, BAUD_DIV, 1'b0);
        check("ov_data", 32'(data), 32'h22);
        check("ov_overrun", 32'(overrun), 1);
        check("ov_valid", 32'(valid), 1);
        check("ov_ferr", 32'(ferr), 0);
        ack_one();
        check("ov_ack_valid", 32'(valid), 0);
        check("ov_ack_overrun", 32'(overrun), 0);
        idle(20);

        // Ack on the exact delivery edge of a second byte
        send_frame(8'h33, 1'b1, BAUD_DIV, 1'b0);
        check("col_first_valid", 32'(valid), 1);
        fork
            send_frame(8'h44, 1'b1, BAUD_DIV, 1'b0);
            begin
                repeat (992) @(negedge clk);
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
                check("col_valid", 32'(valid), 1);
                check("col_overrun", 32'(overrun), 0);
                check("col_data", 32'(data), 32'h44);
            end
        join
        idle(20);

        // Reset during data bit 4, then a clean frame
        fork
            send_frame(8'h96, 1'b1, BAUD_DIV, 1'b0);
            begin
                repeat (5 * BAUD_DIV + 50) @(negedge clk);
                check("mr_busy_before", 32'(busy), 1);
                rst = 1'b1;
                #1;
                check("mr_data", 32'(data), 32'h00);
                check("mr_valid", 32'(valid), 0);
                check("mr_ferr", 32'(ferr), 0);
                check("mr_overrun", 32'(overrun), 0);
                check("mr_busy", 32'(busy), 0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        idle(50);
        check("mr_post_valid", 32'(valid), 0);
        send_frame(8'h5A, 1'b1, BAUD_DIV, 1'b0);
        check("mr_5a_data", 32'(data), 32'h5A);
        check("mr_5a_ferr", 32'(ferr), 0);
        check("mr_5a_valid", 32'(valid), 1);
        ack_one();
        idle(20);

        // Sender baud error of about +/-3% with single-cycle mid-bit glitches
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 3; k++) begin
                send_frame(rb[k], 1'b1, lens[l], 1'b1);
                idle(2 * BAUD_DIV);
                check($sformatf("rb_data_%0d_%0d", lens[l], k), 32'(data), 32'(rb[k]));
                check($sformatf("rb_ferr_%0d_%0d", lens[l], k), 32'(ferr), 0);
                check($sformatf("rb_valid_%0d_%0d", lens[l], k), 32'(valid), 1);
                ack_one();
                check($sformatf("rb_ack_%0d_%0d", lens[l], k), 32'(valid), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Asynchronous serial receiver, 8N1, LSB first: the receive-side companion of the UART transmitter. It synchronises the raw `rx` pin, qualifies the start bit, and recovers each bit by a 3-sample majority vote at mid-bit. Each received byte is delivered through a one-entry holding register with a valid/acknowledge handshake, plus framing-error and overrun flags. It sits between the board's RX pin and the host-facing byte interface.

## Interface

Parameters:
- `BAUD_DIV`, default 104: clock cycles per bit (12 MHz / 115200). Must be ≥ 16.
- `mid` (derived): `BAUD_DIV/2`, integer division. Counter width is `$clog2(BAUD_DIV)`.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial input; asynchronous; idles high.
- `rd_ack`  in  1  consumer acknowledge; clears `valid` and `overrun`.
- `data`  out  8  last received byte.
- `valid`  out  1  `data` holds an unread byte.
- `ferr`  out  1  stop bit of the byte in `data` sampled as 0.
- `overrun`  out  1  a byte was overwritten before it was acknowledged; sticky.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).

## Operation

- **Input synchroniser.** Two flops, `rx` → `s1` → `s2`. Both reset to 1. All logic below uses `s2` only.
- **Counter `cnt`.**
  - Cleared on entry to START.
  - Increments every cycle in START, DATA and STOP.
  - Wraps from `BAUD_DIV-1` to 0.
- **Majority vote.** `s2` is sampled on the edges where `cnt` equals `mid-1`, `mid` and `mid+1`. The bit value is the majority of the 3 samples. It is evaluated on the `cnt==mid+1` edge.
- **State machine.**
  - **IDLE.** When `s2==0`: go to START, `cnt<=0`.
  - **START.**
    - At vote: if the majority is 1, it is a false start; return to IDLE with no output change.
    - Otherwise, when `cnt==BAUD_DIV-1`: go to DATA with `bitc<=0`.
  - **DATA.**
    - At vote: `shifter <= {vote, shifter[7:1]}`.
    - At wrap: if `bitc==7`, go to STOP; else `bitc<=bitc+1`.
  - **STOP.** At vote, return to IDLE immediately; the receiver does not wait out the rest of the stop bit. On the same edge:
    - `data<=shifter`
    - `valid<=1`
    - `ferr<=~vote`
    - `overrun<=overrun | (valid & ~rd_ack)`
- **Framing errors.** A byte with a bad stop bit is still delivered, with `ferr=1`.
- **Handshake.**
  - `rd_ack` while `valid==1` clears `valid` and `overrun` on the next edge.
  - `rd_ack` while `valid==0` has no effect.
  - `data` and `ferr` hold their values until the next delivery.
- **Simultaneous `rd_ack` and delivery.** Delivery wins. `valid` stays 1, new data is loaded, and `overrun` is neither set nor cleared by that edge.
- **Break or line held low.** After STOP returns to IDLE, `s2==0` starts a new frame immediately. A held-low line therefore delivers `0x00` with `ferr=1` repeatedly.

## Timing

- **Reset values.** While `rst` is asserted:
  - state IDLE, `cnt=0`, `bitc=0`, `shifter=0`
  - `data=0x00`, `valid=0`, `ferr=0`, `overrun=0`, `busy=0`
- **Reset mid-frame.** Takes effect immediately and asynchronously. The partial frame is discarded and no delivery occurs.
- **Latency.** Let E0 be the first clk edge at which `rx==0` is captured into `s1`.
  - `valid` rises on edge E0 + 9·`BAUD_DIV` + `mid` + 4.
  - For the default (`BAUD_DIV`=104, `mid`=52) this is E0+992.
- **`busy`.**
  - Rises on edge E0+2.
  - Falls on the delivery edge.
  - On a false start, falls at E0 + `mid` + 4.
- **Tolerance.** A frame is received correctly with sender baud error of up to ±4%.
- **Back-to-back frames.** A start edge immediately after a nominal stop bit is captured, because IDLE is re-entered about half a bit early.

## Test plan

- **Nominal byte.** Send 0xA5 at `BAUD_DIV`=104 with a correct stop bit → `valid` rises at E0+992 with `data`=0xA5 and `ferr`=0. Assert `rd_ack` one cycle → `valid`=0 on the next edge.
- **Glitch rejection.** Pulse `rx` low for 20 cycles, then high → `busy` pulses, then returns to 0. No `valid`, and `data` is unchanged.
- **Framing error.** Send 0x3C with the stop bit driven 0 → `data`=0x3C, `ferr`=1, `valid`=1.
- **Overrun.** Send 0x11 then 0x22 back-to-back with no `rd_ack` → `data`=0x22 and `overrun`=1. Assert `rd_ack` → `valid`=0 and `overrun`=0.
- **Ack collision.** Assert `rd_ack` on exactly the delivery edge of a second byte → `valid`=1, `overrun`=0, `data`=new byte.
- **Robustness.** Assert `rst` mid-frame during bit 4 → all outputs return to their reset values. A following clean 0x5A is received correctly. Repeat 0x00/0xFF/0x55 with ±3% sender baud error and single-cycle mid-bit glitches → all bytes are correct with `ferr`=0.
